serial_addsub_word: RTL and testbench

- Parametrised successor to the team's 1-bit serial adder FSM.
- Adds or subtracts two WIDTH-bit words streamed LSB-first, DIGIT bits per accepted beat.
- Supports a word framing handshake, input stalls, and per-word carry/overflow flags.
- Sits between the switch/shift-register front end and the LED/seven-segment display path on the Boolean Board.

---
 rtl/serial_addsub_word.sv | 147 ++++++++++++++
 tb/tb_serial_addsub_word.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_word.sv
// serial_addsub_word: adds or subtracts two WIDTH-bit words streamed LSB-first,
// DIGIT bits per accepted beat, with word framing, input stalls and per-word
// carry/overflow flags.
//
// Optional feature: define SERIAL_ADDSUB_PARALLEL_OUT_EN to add the sum_word
// output, which collects the whole result word in parallel.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   begin a new word (also aborts a word in progress); sub sampled with it
//   sub        in   0 = A+B, 1 = A-B
//   in_valid   in   a/b carry a valid digit this cycle
//   a, b       in   operand digits [DIGIT-1:0], LSB-first
//   busy       out  high while a word is in progress or completing
//   out_valid  out  s holds a fresh result digit
//   s          out  registered result digit [DIGIT-1:0]
//   done       out  one-cycle pulse alongside the final digit
//   cout       out  final carry of the last word (subtract: 1 = no borrow)
//   ovf        out  two's-complement overflow of the last word
//   sum_word   out  [WIDTH-1:0] assembled result (SERIAL_ADDSUB_PARALLEL_OUT_EN only)
module serial_addsub_word #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             in_valid,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             busy,
    output logic             out_valid,
    output logic [DIGIT-1:0] s,
    output logic             done,
    output logic             cout,
    output logic             ovf
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
    ,
    output logic [WIDTH-1:0] sum_word
`endif
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_addsub_word: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic             r_carry, r_mode, r_out_valid, r_cout, r_ovf;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT-1:0] r_s;
    logic [DIGIT-1:0] w_bop;
    logic [DIGIT:0]   w_sum;
    logic             w_cmsb;
    logic             w_accept;
    logic             w_last;

    // Subtract is A + ~B + 1; the +1 comes from the carry preset on start.
    assign w_bop    = r_mode ? ~b : b;
    assign w_sum    = {1'b0, a} + {1'b0, w_bop} + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit MSB, recovered from the MSB sum bit.
    assign w_cmsb   = a[DIGIT-1] ^ w_bop[DIGIT-1] ^ w_sum[DIGIT-1];
    // start wins over in_valid in RUN: the beat belongs to the aborted word.
    assign w_accept = (r_state == S_RUN) && !start && in_valid;
    assign w_last   = (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (!start && in_valid && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_carry     <= 1'b0;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_s         <= '0;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (start) begin
                r_carry <= sub;
                r_mode  <= sub;
                r_cnt   <= '0;
            end else if (w_accept) begin
                r_s         <= w_sum[DIGIT-1:0];
                r_carry     <= w_sum[DIGIT];
                r_out_valid <= 1'b1;
                r_cnt       <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_cout <= w_sum[DIGIT];
                    r_ovf  <= w_cmsb ^ w_sum[DIGIT];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_sum <= '0;
        else if (start)    r_sum <= '0;
        else if (w_accept) r_sum[r_cnt*DIGIT +: DIGIT] <= w_sum[DIGIT-1:0];
    end

    assign sum_word = r_sum;
`endif

endmodule

// File: tb/tb_serial_addsub_word.sv
// Directed bench for serial_addsub_word: one DIGIT=1 instance for the main
// sequence and one DIGIT=4 instance for the stalled multi-bit digit case.
module tb_serial_addsub_word;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DIGIT = 1 instance
    logic       st1 = 1'b0, sb1 = 1'b0, iv1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       bz1, ov1, dn1, co1, of1;
    logic [0:0] s1;
    // DIGIT = 4 instance
    logic       st4 = 1'b0, sb4 = 1'b0, iv4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       bz4, ov4, dn4, co4, of4;
    logic [3:0] s4;
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
    logic [7:0] sw1, sw4;
`endif

    int n_chk = 0;
    int n_err = 0;

    serial_addsub_word #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .sub(sb1), .in_valid(iv1),
        .a(a1), .b(b1), .busy(bz1), .out_valid(ov1), .s(s1), .done(dn1),
        .cout(co1), .ovf(of1)
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
        , .sum_word(sw1)
`endif
    );

    serial_addsub_word #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(st4), .sub(sb4), .in_valid(iv4),
        .a(a4), .b(b4), .busy(bz4), .out_valid(ov4), .s(s4), .done(dn4),
        .cout(co4), .ovf(of4)
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
        , .sum_word(sw4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge on the DIGIT=1 instance.
    task automatic begin_word(input logic sb, input logic ivv);
        st1 = 1'b1; sb1 = sb; iv1 = ivv; a1 = 1'b1; b1 = 1'b1;
        step();
        st1 = 1'b0; iv1 = 1'b0;
    endtask

    // Feed n digits back to back; collects s and counts out_valid/done.
    task automatic feed(input logic [7:0] A, input logic [7:0] B, input int n,
                        output logic [7:0] res, output int nov, output int nd);
        res = '0; nov = 0; nd = 0;
        for (int i = 0; i < n; i++) begin
            iv1 = 1'b1; a1 = A[i]; b1 = B[i];
            step();
            res[i] = s1[0];
            nov += int'(ov1);
            nd  += int'(dn1);
        end
        iv1 = 1'b0;
    endtask

    initial begin
        logic [7:0] res;
        int nov, nd;

        // Reset state
        step(); step();
        chk("rst_busy1", bz1, 0); chk("rst_ov1", ov1, 0); chk("rst_s1", s1, 0);
        chk("rst_done1", dn1, 0); chk("rst_cout1", co1, 0); chk("rst_ovf1", of1, 0);
        chk("rst_busy4", bz4, 0); chk("rst_s4", s4, 0);
        rst = 1'b1;
        step();
        chk("idle_busy", bz1, 0);

        // 0x5A + 0x3C = 0x96, signed overflow
        begin_word(1'b0, 1'b0);
        chk("t1_busy", bz1, 1); chk("t1_ov0", ov1, 0);
        feed(8'h5A, 8'h3C, 8, res, nov, nd);
        chk("t1_res", res, 8'h96); chk("t1_nov", nov, 8); chk("t1_nd", nd, 1);
        chk("t1_done_last", dn1, 1); chk("t1_ov_last", ov1, 1);
        chk("t1_cout", co1, 0); chk("t1_ovf", of1, 1);
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
        chk("t1_sw", sw1, 8'h96);
`endif
        step();
        chk("t1_idle_busy", bz1, 0); chk("t1_idle_done", dn1, 0); chk("t1_idle_ov", ov1, 0);

        // 0x10 - 0x20 = 0xF0, borrow
        begin_word(1'b1, 1'b0);
        feed(8'h10, 8'h20, 8, res, nov, nd);
        chk("t2a_res", res, 8'hF0); chk("t2a_cout", co1, 0); chk("t2a_ovf", of1, 0);
        step();
        // 0x80 - 0x01 = 0x7F, no borrow, overflow
        begin_word(1'b1, 1'b0);
        feed(8'h80, 8'h01, 8, res, nov, nd);
        chk("t2b_res", res, 8'h7F); chk("t2b_cout", co1, 1); chk("t2b_ovf", of1, 1);
        step();

        // Asynchronous reset mid-word
        begin_word(1'b0, 1'b0);
        feed(8'hFF, 8'h00, 3, res, nov, nd);
        chk("rs_pre_s", s1, 1); chk("rs_pre_cout", co1, 1);
        #2 rst = 1'b0;
        #1;
        chk("rs_busy", bz1, 0); chk("rs_ov", ov1, 0); chk("rs_s", s1, 0);
        chk("rs_cout", co1, 0); chk("rs_ovf", of1, 0);
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
        chk("rs_sw", sw1, 0);
`endif
        #2 rst = 1'b1;
        begin_word(1'b0, 1'b0);
        feed(8'h7F, 8'h01, 8, res, nov, nd);
        chk("rs_res", res, 8'h80); chk("rs_cout2", co1, 0); chk("rs_ovf2", of1, 1);
        step();

        // Back-to-back: start during DONE
        begin_word(1'b0, 1'b0);
        feed(8'h03, 8'h04, 8, res, nov, nd);
        chk("bb1_res", res, 8'h07); chk("bb1_nd", nd, 1); chk("bb1_done", dn1, 1);
        begin_word(1'b0, 1'b0);
        chk("bb_busy", bz1, 1); chk("bb_done_gone", dn1, 0);
        feed(8'h01, 8'h01, 8, res, nov, nd);
        chk("bb2_res", res, 8'h02); chk("bb2_nd", nd, 1);
        chk("bb2_cout", co1, 0); chk("bb2_ovf", of1, 0);
        step();

        // Abort after 3 digits; the in_valid beat alongside start is dropped
        begin_word(1'b0, 1'b0);
        feed(8'hAA, 8'h55, 3, res, nov, nd);
        chk("ab_nd", nd, 0);
        begin_word(1'b0, 1'b1);
        chk("ab_ov", ov1, 0); chk("ab_done", dn1, 0); chk("ab_busy", bz1, 1);
        feed(8'h0F, 8'h01, 8, res, nov, nd);
        chk("ab_res", res, 8'h10); chk("ab_nd2", nd, 1); chk("ab_cout", co1, 0);
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
        chk("ab_sw", sw1, 8'h10);
`endif
        step();

        // DIGIT=4: 0xFF + 0x01 with a two-cycle stall between beats
        st4 = 1'b1; sb4 = 1'b0;
        step();
        st4 = 1'b0;
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'h1;
        step();
        chk("d4_ov_b0", ov4, 1); chk("d4_s_b0", s4, 4'h0); chk("d4_done_b0", dn4, 0);
        iv4 = 1'b0; a4 = 4'h3; b4 = 4'h3;
        step();
        chk("d4_stall1_ov", ov4, 0); chk("d4_stall1_busy", bz4, 1);
        step();
        chk("d4_stall2_ov", ov4, 0); chk("d4_stall2_done", dn4, 0);
        iv4 = 1'b1; a4 = 4'hF; b4 = 4'h0;
        step();
        iv4 = 1'b0;
        chk("d4_ov_b1", ov4, 1); chk("d4_s_b1", s4, 4'h0); chk("d4_done", dn4, 1);
        chk("d4_cout", co4, 1); chk("d4_ovf", of4, 0);
`ifdef SERIAL_ADDSUB_PARALLEL_OUT_EN
        chk("d4_sw", sw4, 8'h00);
`endif
        step();
        chk("d4_idle_done", dn4, 0); chk("d4_idle_busy", bz4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
